// File: rtl/gtech_piso8_if.sv
// gtech_piso8_if
// Bus between a parallel register stage, the gtech_piso8 serializer and the
// serial consumer: word handshake (D/LD_VALID/LD_READY), per-bit consumer
// enable (SO_EN) and the serial framing outputs.
// The producer/consumer side uses the master modport. The serializer uses the
// slave modport.
interface gtech_piso8_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] D;
   logic             LD_VALID;
   logic             LD_READY;
   logic             SO_EN;
   logic             SO;
   logic             SO_VALID;
   logic             SO_LAST;
   logic             BUSY;

   modport master (
      output D, LD_VALID, SO_EN,
      input  LD_READY, SO, SO_VALID, SO_LAST, BUSY
   );

   modport slave (
      input  D, LD_VALID, SO_EN,
      output LD_READY, SO, SO_VALID, SO_LAST, BUSY
   );
endinterface

// File: rtl/gtech_piso8.sv
// gtech_piso8
// Parallel-in / serial-out transmitter. It accepts one WIDTH-bit word per
// LD_VALID & LD_READY handshake and sends it one bit per SO_EN cycle.
// Bit order: MSB first by default, or LSB first when LSB_FIRST=1.
// SO, SO_VALID and SO_LAST are registered. LD_READY is combinational, so the
// next word can be accepted on the last bit of the current frame with no gap.
// Optional feature: defining GTECH_PISO_PARITY_EN adds a trailing even-parity
// bit, which becomes the SO_LAST bit of each frame.
module gtech_piso8 #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic          CP,
   input  logic          RST,
   gtech_piso8_if.slave  bus
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1
`ifdef GTECH_PISO_PARITY_EN
      , S_PAR = 2'd2
`endif
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_cnt;
   logic             r_so;
   logic             r_soValid;
   logic             r_soLast;
`ifdef GTECH_PISO_PARITY_EN
   logic             r_parity;
`endif

   state_t           w_nextState;
   logic [WIDTH-1:0] w_nextShift;
   logic [CNT_W-1:0] w_nextCnt;
   logic             w_nextSo;
   logic             w_nextValid;
   logic             w_nextLast;
   logic             w_ldReady;
   logic             w_load;

   // Bit that leaves the shift register next.
   function automatic logic headBit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   // Advance the shift register by one bit, moving the next bit into the head position.
   function automatic logic [WIDTH-1:0] shiftOnce(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
   endfunction

   // Next-state, handshake and next registered-output decode. A load always wins, so a frame can start
   // directly from its predecessor's final bit.
   always_comb begin
      w_ldReady   = 1'b0;
      w_nextState = r_state;
      w_nextShift = r_shift;
      w_nextCnt   = r_cnt;
      w_nextSo    = 1'b0;
      w_nextValid = 1'b0;
      w_nextLast  = 1'b0;

      case (r_state)
         S_IDLE:  w_ldReady = 1'b1;
`ifdef GTECH_PISO_PARITY_EN
         S_SHIFT: w_ldReady = 1'b0;
         S_PAR:   w_ldReady = bus.SO_EN;
`else
         S_SHIFT: w_ldReady = bus.SO_EN && (r_cnt == '0);
`endif
         default: w_ldReady = 1'b0;
      endcase
      if (RST) begin
         w_ldReady = 1'b0;
      end
      w_load = bus.LD_VALID && w_ldReady;

      case (r_state)
         S_IDLE: begin
            w_nextState = S_IDLE;
         end
         S_SHIFT: begin
            if (bus.SO_EN) begin
               if (r_cnt == '0) begin
`ifdef GTECH_PISO_PARITY_EN
                  w_nextState = S_PAR;
`else
                  w_nextState = S_IDLE;
                  w_nextShift = '0;
`endif
               end else begin
                  w_nextShift = shiftOnce(r_shift);
                  w_nextCnt   = r_cnt - 1'b1;
               end
            end
         end
`ifdef GTECH_PISO_PARITY_EN
         S_PAR: begin
            if (bus.SO_EN) begin
               w_nextState = S_IDLE;
               w_nextShift = '0;
            end
         end
`endif
         default: begin
            w_nextState = S_IDLE;
            w_nextShift = '0;
            w_nextCnt   = '0;
         end
      endcase

      if (w_load) begin
         w_nextState = S_SHIFT;
         w_nextShift = bus.D;
         w_nextCnt   = CNT_FIRST;
      end

      w_nextValid = (w_nextState != S_IDLE);
      if (w_nextState == S_SHIFT) begin
         w_nextSo = headBit(w_nextShift);
      end
`ifdef GTECH_PISO_PARITY_EN
      if (w_nextState == S_PAR) begin
         w_nextSo = r_parity;
      end
      w_nextLast = (w_nextState == S_PAR);
`else
      w_nextLast = (w_nextState == S_SHIFT) && (w_nextCnt == '0);
`endif
   end

   // State, shift register, counter and registered serial outputs. Reset aborts any frame in progress.
   always_ff @(posedge CP) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_cnt     <= '0;
         r_so      <= 1'b0;
         r_soValid <= 1'b0;
         r_soLast  <= 1'b0;
      end else begin
         r_state   <= w_nextState;
         r_shift   <= w_nextShift;
         r_cnt     <= w_nextCnt;
         r_so      <= w_nextSo;
         r_soValid <= w_nextValid;
         r_soLast  <= w_nextLast;
      end
   end

`ifdef GTECH_PISO_PARITY_EN
   // Even parity of the word, captured at load time so the shift register is free to move.
   always_ff @(posedge CP) begin
      if (RST) begin
         r_parity <= 1'b0;
      end else if (w_load) begin
         r_parity <= ^bus.D;
      end
   end
`endif

   assign bus.LD_READY = w_ldReady;
   assign bus.SO       = r_so;
   assign bus.SO_VALID = r_soValid;
   assign bus.SO_LAST  = r_soLast;
   assign bus.BUSY     = (r_state != S_IDLE);

endmodule
